// File: rtl/lsu_lane_align.sv
// Byte-lane aligner for loads/stores with a one-entry registered output stage.
// Build with LR_MERGE_EN defined to include the LWL/LWR/SWL/SWR merge ops.
module lsu_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [$clog2(DATA_W/8)-1:0] in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [DATA_W-1:0]     in_rdata,
    input  logic [DATA_W-1:0]     in_rt_old,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W/8-1:0]   out_strb,
    output logic [DATA_W-1:0]     out_wdata,
    output logic [DATA_W-1:0]     out_ldata,
    output logic                  out_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int AW    = $clog2(BYTES);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LD  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SD  = 4'd13;
`ifdef LR_MERGE_EN
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;
`endif

    logic [AW-1:0]   half_base, word_base;
    logic [AW+2:0]   byte_sh, half_sh, word_sh;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     word_v;

    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [BYTES-1:0]    strb_q, strb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   ldata_q, ldata_d;
    logic                accept;

    // Lane bases: halfword/word accesses start at the aligned boundary below in_addr.
    assign half_base = in_addr & ~AW'(1);
    assign word_base = in_addr & ~AW'(3);
    assign byte_sh   = {in_addr, 3'b000};
    assign half_sh   = {half_base, 3'b000};
    assign word_sh   = {word_base, 3'b000};
    assign byte_v    = 8'(in_rdata >> byte_sh);
    assign half_v    = 16'(in_rdata >> half_sh);
    assign word_v    = 32'(in_rdata >> word_sh);

`ifdef LR_MERGE_EN
    logic [1:0]  k;
    logic [31:0] lwl_v, lwr_v, swl_d, swr_d;
    logic [3:0]  swl_m, swr_m;

    assign k     = in_addr[1:0];
    assign lwl_v = (word_v << {2'd3 - k, 3'b000})
                 | (in_rt_old[31:0] & (32'hFFFF_FFFF >> {3'(k) + 3'd1, 3'b000}));
    assign lwr_v = (word_v >> {k, 3'b000})
                 | (in_rt_old[31:0] & ~(32'hFFFF_FFFF >> {k, 3'b000}));
    assign swl_m = 4'hF >> (2'd3 - k);
    assign swr_m = 4'hF << k;
    assign swl_d = in_wdata[31:0] >> {2'd3 - k, 3'b000};
    assign swr_d = in_wdata[31:0] << {k, 3'b000};
`endif

    always_comb begin
        err_d   = 1'b0;
        strb_d  = '0;
        wdata_d = '0;
        ldata_d = '0;
        case (in_op)
            OP_LB:  ldata_d = DATA_W'($signed(byte_v));
            OP_LBU: ldata_d = DATA_W'(byte_v);
            OP_LH: begin
                err_d   = in_addr[0];
                ldata_d = DATA_W'($signed(half_v));
            end
            OP_LHU: begin
                err_d   = in_addr[0];
                ldata_d = DATA_W'(half_v);
            end
            OP_LW: begin
                err_d   = (in_addr[1:0] != 2'b00);
                ldata_d = DATA_W'($signed(word_v));
            end
            OP_LD: begin
                err_d   = (DATA_W == 32) || (in_addr != '0);
                ldata_d = in_rdata;
            end
            OP_SB: begin
                strb_d  = BYTES'(1) << in_addr;
                wdata_d = DATA_W'(in_wdata[7:0]) << byte_sh;
            end
            OP_SH: begin
                err_d   = in_addr[0];
                strb_d  = BYTES'(2'b11) << half_base;
                wdata_d = DATA_W'(in_wdata[15:0]) << half_sh;
            end
            OP_SW: begin
                err_d   = (in_addr[1:0] != 2'b00);
                strb_d  = BYTES'(4'hF) << word_base;
                wdata_d = DATA_W'(in_wdata[31:0]) << word_sh;
            end
            OP_SD: begin
                err_d   = (DATA_W == 32) || (in_addr != '0);
                strb_d  = '1;
                wdata_d = in_wdata;
            end
`ifdef LR_MERGE_EN
            OP_LWL: ldata_d = DATA_W'($signed(lwl_v));
            OP_LWR: ldata_d = DATA_W'($signed(lwr_v));
            OP_SWL: begin
                strb_d  = BYTES'(swl_m) << word_base;
                wdata_d = DATA_W'(swl_d) << word_sh;
            end
            OP_SWR: begin
                strb_d  = BYTES'(swr_m) << word_base;
                wdata_d = DATA_W'(swr_d) << word_sh;
            end
`endif
            default: err_d = 1'b1;
        endcase
        // A faulting access writes nothing and leaves rt unchanged.
        if (err_d) begin
            strb_d  = '0;
            wdata_d = '0;
            ldata_d = in_rt_old;
        end
    end

    // Handshake: a beat transfers on an edge where valid && ready; the output
    // register holds while out_valid && !out_ready, and flush drops both the
    // held beat and any beat accepted in the same cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept && !flush) begin
                err_q   <= err_d;
                strb_q  <= strb_d;
                wdata_q <= wdata_d;
                ldata_q <= ldata_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_err   = err_q;
    assign out_strb  = strb_q;
    assign out_wdata = wdata_q;
    assign out_ldata = ldata_q;
endmodule

// File: tb/tb_lsu_lane_align.sv
// Bench for lsu_lane_align: 32- and 64-bit instances driven in lockstep and
// checked against a byte-array reference model through an expected queue.
module tb_lsu_lane_align;
`ifdef LR_MERGE_EN
    localparam bit LR_EN = 1'b1;
`else
    localparam bit LR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        err;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] ldata;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [3:0]  op_r;
    logic [2:0]  addr_r;
    logic [63:0] wd_r, rd_r, rt_r;

    logic        in_ready32, out_valid32, out_err32;
    logic [3:0]  out_strb32;
    logic [31:0] out_wdata32, out_ldata32;
    logic        in_ready64, out_valid64, out_err64;
    logic [7:0]  out_strb64;
    logic [63:0] out_wdata64, out_ldata64;

    res_t exp32_q[$];
    res_t exp64_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_on = 1'b0;
    bit   rst_seen = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_lane_align #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_op(op_r), .in_addr(addr_r[1:0]), .in_wdata(wd_r[31:0]), .in_rdata(rd_r[31:0]),
        .in_rt_old(rt_r[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .out_strb(out_strb32), .out_wdata(out_wdata32), .out_ldata(out_ldata32), .out_err(out_err32)
    );

    lsu_lane_align #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_op(op_r), .in_addr(addr_r), .in_wdata(wd_r), .in_rdata(rd_r),
        .in_rt_old(rt_r), .out_valid(out_valid64), .out_ready(out_ready),
        .out_strb(out_strb64), .out_wdata(out_wdata64), .out_ldata(out_ldata64), .out_err(out_err64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic res_t model(input int nb, input logic [3:0] op, input int a_in,
                                   input logic [63:0] wd_in, input logic [63:0] rd_in,
                                   input logic [63:0] rt_in);
        res_t r;
        logic [7:0]  m [8];
        logic [7:0]  res_b [8];
        logic [63:0] wd, rd, rt;
        int a, k, wb, size;
        bit is_load, sgn, err;
        r = '0;
        wd = wd_in; rd = rd_in; rt = rt_in;
        if (nb == 4) begin
            wd[63:32] = '0; rd[63:32] = '0; rt[63:32] = '0;
        end
        a = a_in % nb;
        k = a % 4;
        wb = a - k;
        size = 0; is_load = 0; sgn = 0; err = 0;
        case (op)
            4'd0: begin size = 1; is_load = 1; sgn = 1; end
            4'd1: begin size = 1; is_load = 1; end
            4'd2: begin size = 2; is_load = 1; sgn = 1; end
            4'd3: begin size = 2; is_load = 1; end
            4'd4: begin size = 4; is_load = 1; sgn = 1; end
            4'd7: begin size = 8; is_load = 1; end
            4'd8: size = 1;
            4'd9: size = 2;
            4'd10: size = 4;
            4'd13: size = 8;
            4'd5, 4'd6, 4'd11, 4'd12: err = !LR_EN;
            default: err = 1;
        endcase
        if (size != 0 && (size > nb || (a % size) != 0)) err = 1;
        if (err) begin
            r.err = 1'b1;
            r.ldata = rt;
            return r;
        end
        for (int i = 0; i < 8; i++) begin
            m[i] = rd[8*i +: 8];
            res_b[i] = 8'h00;
        end
        if (is_load) begin
            for (int j = 0; j < size; j++) res_b[j] = m[a + j];
            if (sgn && res_b[size-1][7])
                for (int j = size; j < nb; j++) res_b[j] = 8'hFF;
        end else if (op == 4'd5 || op == 4'd6) begin
            for (int i = 0; i < 4; i++) begin
                res_b[i] = rt[8*i +: 8];
                if (op == 4'd5 && i >= 3 - k) res_b[i] = m[wb + i - 3 + k];
                if (op == 4'd6 && i <= 3 - k) res_b[i] = m[wb + i + k];
            end
            if (res_b[3][7])
                for (int j = 4; j < nb; j++) res_b[j] = 8'hFF;
        end else if (op == 4'd11) begin
            for (int j = 0; j <= k; j++) begin
                r.strb[wb + j] = 1'b1;
                r.wdata[8*(wb + j) +: 8] = wd[8*(j + 3 - k) +: 8];
            end
        end else if (op == 4'd12) begin
            for (int j = k; j < 4; j++) begin
                r.strb[wb + j] = 1'b1;
                r.wdata[8*(wb + j) +: 8] = wd[8*(j - k) +: 8];
            end
        end else begin
            for (int j = 0; j < size; j++) begin
                r.strb[a + j] = 1'b1;
                r.wdata[8*(a + j) +: 8] = wd[8*j +: 8];
            end
        end
        for (int j = 0; j < nb; j++) r.ldata[8*j +: 8] = res_b[j];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        bit   exp_valid;
        res_t e;
        exp_valid = (exp32_q.size() != 0);
        if (rst_seen) begin
            check("rst_strb32", out_strb32, 0);   check("rst_wdata32", out_wdata32, 0);
            check("rst_ldata32", out_ldata32, 0); check("rst_err32", out_err32, 0);
            check("rst_strb64", out_strb64, 0);   check("rst_wdata64", out_wdata64, 0);
            check("rst_ldata64", out_ldata64, 0); check("rst_err64", out_err64, 0);
        end
        rst_seen = rst;
        check("valid32", out_valid32, exp_valid);
        check("valid64", out_valid64, exp64_q.size() != 0);
        check("in_ready32", in_ready32, !exp_valid || out_ready);
        check("in_ready64", in_ready64, !exp_valid || out_ready);
        if (exp_valid && out_valid32) begin
            e = exp32_q[0];
            check("err32", out_err32, e.err);     check("strb32", out_strb32, e.strb);
            check("wdata32", out_wdata32, e.wdata); check("ldata32", out_ldata32, e.ldata);
        end
        if (exp64_q.size() != 0 && out_valid64) begin
            e = exp64_q[0];
            check("err64", out_err64, e.err);     check("strb64", out_strb64, e.strb);
            check("wdata64", out_wdata64, e.wdata); check("ldata64", out_ldata64, e.ldata);
        end
        if (rst) begin
            exp32_q.delete();
            exp64_q.delete();
        end else begin
            if (exp_valid && (out_ready || flush)) begin
                void'(exp32_q.pop_front());
                void'(exp64_q.pop_front());
            end
            if (in_valid && (!exp_valid || out_ready) && !flush) begin
                exp32_q.push_back(model(4, op_r, int'(addr_r), wd_r, rd_r, rt_r));
                exp64_q.push_back(model(8, op_r, int'(addr_r), wd_r, rd_r, rt_r));
            end
        end
    end

    // Random backpressure and flush while the random phase runs.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_on) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_beat(input logic [3:0] op, input logic [2:0] addr,
                            input logic [63:0] wd, input logic [63:0] rd, input logic [63:0] rt);
        op_r = op; addr_r = addr; wd_r = wd; rd_r = rd; rt_r = rt;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] addr,
                        input logic [63:0] wd, input logic [63:0] rd, input logic [63:0] rt);
        logic acc;
        int   guard;
        set_beat(op, addr, wd, rd, rt);
        guard = 0;
        do begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        check("accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand();
        send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_r = '0; addr_r = '0; wd_r = '0; rd_r = '0; rt_r = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors from the access rules
        send(4'd0, 3'd2, 64'h0, 64'h80FF1234, 64'h5555AAAA);
        send(4'd1, 3'd3, 64'h0, 64'h80FF1234, 64'h5555AAAA);
        send(4'd9, 3'd6, 64'h1111_2222_3333_BEEF, 64'h0, 64'h77);
        send(4'd9, 3'd5, 64'h1111_2222_3333_BEEF, 64'h0, 64'h77);
        send(4'd5, 3'd1, 64'h0, 64'hAABBCCDD, 64'h11223344);
        send(4'd6, 3'd2, 64'h0, 64'hAABBCCDD, 64'h11223344);
        send(4'd11, 3'd1, 64'h12345678, 64'h0, 64'h0);
        send(4'd12, 3'd1, 64'h12345678, 64'h0, 64'h0);
        send(4'd15, 3'd0, 64'h1, 64'h2, 64'hDEAD_BEEF_CAFE_F00D);
        send(4'd7, 3'd0, 64'h0, 64'h8899AABB_CCDDEEFF, 64'h3);
        send(4'd13, 3'd0, 64'h0102030405060708, 64'h0, 64'h0);
        idle(2);

        // Stall: held output stays put and in_ready drops for three cycles
        out_ready = 1'b0;
        send(4'd4, 3'd4, 64'h0, 64'hF0E0D0C0_B0A09080, 64'h0);
        set_beat(4'd8, 3'd7, 64'h5A, 64'h0, 64'h0);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready32", in_ready32, 1'b0);
            check("stall_in_ready64", in_ready64, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        c0 = cyc;
        send(4'd8, 3'd7, 64'h5A, 64'h0, 64'h0);
        send(4'd3, 3'd2, 64'h0, 64'h0000_8001_0000_0000, 64'h0);
        send(4'd10, 3'd0, 64'hCAFEBABE, 64'h0, 64'h0);
        send(4'd2, 3'd6, 64'h0, 64'h8001_0000_0000_0000, 64'h0);
        check("no_bubble_cycles", cyc - c0, 4);
        idle(2);

        // Flush with a held beat and a simultaneously accepted beat
        out_ready = 1'b0;
        send(4'd1, 3'd1, 64'h0, 64'h0000_FF00, 64'h0);
        set_beat(4'd0, 3'd0, 64'h0, 64'h80, 64'h0);
        out_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid32", out_valid32, 1'b0);
        check("flush_valid64", out_valid64, 1'b0);
        @(posedge clk);
        #1;

        // Reset in the middle of traffic
        send(4'd8, 3'd1, 64'hA5, 64'h0, 64'h0);
        set_beat(4'd4, 3'd0, 64'h0, 64'h8000_0000, 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_valid32", out_valid32, 1'b0);
        check("rst_valid64", out_valid64, 1'b0);
        @(posedge clk);
        #1;

        // Randomized traffic with backpressure and occasional flushes
        rand_on = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_rand();
        end
        idle(1);
        rand_on = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle(3);
        @(negedge clk);
        check("drain32", exp32_q.size(), 0);
        check("drain64", exp64_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
